// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM encoding and counter sizing for the sequential divider
package divisor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;
  function automatic int ancho_cnt(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/divisor_paso.sv
// divisor_paso: one combinational restoring-division step (shift, trial subtract, borrow test)
module divisor_paso #(
  parameter int width = 8
) (
  input  logic [width-1:0] r,
  input  logic             q_msb,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] r_sig,
  output logic             q_bit
);
  logic [width:0] shifted, trial;
  // the old remainder MSB stays in the top bit so the shift never loses weight
  assign shifted = {r, q_msb};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[width];
  assign r_sig   = trial[width] ? shifted[width-1:0] : trial[width-1:0];
endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: multi-cycle unsigned restoring divider, one quotient bit per clock
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero
);
  localparam int cw = ancho_cnt(width);
  estado_t          estado, estado_sig;
  logic [cw-1:0]    cnt;
  logic [width-1:0] divisor, r_sig;
  logic             q_bit;
  divisor_paso #(.width(width)) u_paso (
    .r      (r),
    .q_msb  (q[width-1]),
    .divisor(divisor),
    .r_sig  (r_sig),
    .q_bit  (q_bit)
  );
  always_ff @(posedge clk)
    estado <= reset ? IDLE : estado_sig;
  always_comb
    estado_sig = (estado == IDLE) ? (start ? RUN : IDLE) :
                 (estado == RUN)  ? ((cnt == '0) ? DONE : RUN) : IDLE;
  always_comb begin
    busy = estado != IDLE;
    done = estado == DONE;
  end
  // q doubles as the dividend shift register; results hold until the next accept
  always_ff @(posedge clk)
    if (reset) begin
      q           <= '0;
      r           <= '0;
      divisor     <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (estado == IDLE && start) begin
      q           <= a;
      r           <= '0;
      divisor     <= b;
      cnt         <= cw'(width - 1);
      div_by_zero <= b == '0;
    end else if (estado == RUN) begin
      q   <= {q[width-2:0], q_bit};
      r   <= r_sig;
      cnt <= cnt - 1'b1;
    end
endmodule
